// File: rtl/sol32_pkg.sv
// Shared types and lane helpers for the sol32 load/store path.
package sol32_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_t;
    typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD, W_RSVD} width_t;

    // Byte offset inside the word; bits below the access width are dropped.
    function automatic logic [1:0] lane_off(input logic [1:0] width, input logic [1:0] addr);
        case (width_t'(width))
            W_BYTE:  return addr;
            W_HALF:  return {addr[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr);
        case (width_t'(width))
            W_BYTE:  return 1'b0;
            W_HALF:  return addr[0];
            default: return |addr;
        endcase
    endfunction

endpackage

// File: rtl/sol32_lane_align.sv
// Combinational byte-lane steering: store data into lanes, load data out of lanes.
module sol32_lane_align
    import sol32_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_off;
    logic [4:0]  w_sh;
    logic [31:0] w_mask;

    always_comb begin
        w_off  = lane_off(i_width, i_addr);
        w_sh   = {w_off, 3'b000};
        w_mask = 32'hffff_ffff;
        o_be   = 4'b1111;
        case (width_t'(i_width))
            W_BYTE: begin
                w_mask = 32'h0000_00ff;
                o_be   = 4'b0001 << w_off;
            end
            W_HALF: begin
                w_mask = 32'h0000_ffff;
                o_be   = 4'b0011 << w_off;
            end
            default: ;
        endcase
    end

    // Mask before shifting so stray upper store bits never reach other lanes.
    assign o_wdata = (i_wdata & w_mask) << w_sh;
    assign o_rdata = (i_rdata >> w_sh) & w_mask;

endmodule

// File: rtl/sol32_lsu.sv
// sol32 load/store unit: level-held core enables -> one valid/ready bus access.
// Optional SOL32_LSU_ALIGN_CHECK_EN: misaligned accesses fault without touching the bus.
module sol32_lsu
    import sol32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReadEnable,
    input  logic        WriteEnable,
    input  logic [1:0]  DataWidth,
    input  logic [31:0] MemoryAddress,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        ReadComplete,
    output logic        WriteComplete,
    output logic        Fault,
    output logic        BusValid,
    output logic        BusWrite,
    output logic [31:0] BusAddress,
    output logic [3:0]  BusByteEnable,
    output logic [31:0] BusWriteData,
    input  logic        BusReady,
    input  logic        BusReadValid,
    input  logic [31:0] BusReadData
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);

    lsu_state_t           r_state, w_next;
    logic                 r_write, r_fault;
    logic [1:0]           r_width;
    logic [31:0]          r_addr, r_wdata, r_data;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 w_req, w_misalign, w_timeout, w_fault_set, w_busy;
    logic [31:0]          w_ld_data;

    assign w_req  = ReadEnable | WriteEnable;
    assign w_busy = (r_state == REQ) || (r_state == WAIT_R);

`ifdef SOL32_LSU_ALIGN_CHECK_EN
    assign w_misalign = misaligned(DataWidth, MemoryAddress[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // >= so a read accepted on the last REQ cycle still times out in WAIT_R.
    assign w_timeout = TO_EN && w_busy && (r_cnt >= TO_LAST);

    // A real handshake in the final cycle wins over the timeout.
    always_comb begin
        w_next      = r_state;
        w_fault_set = 1'b0;
        case (r_state)
            IDLE: if (w_req) begin
                if (w_misalign) begin
                    w_next      = DONE;
                    w_fault_set = 1'b1;
                end else begin
                    w_next = REQ;
                end
            end
            REQ: if (BusReady) begin
                w_next = r_write ? DONE : WAIT_R;
            end else if (w_timeout) begin
                w_next      = DONE;
                w_fault_set = 1'b1;
            end
            WAIT_R: if (BusReadValid) begin
                w_next = DONE;
            end else if (w_timeout) begin
                w_next      = DONE;
                w_fault_set = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_fault <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_width <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_fault <= w_fault_set;
            if (r_state == IDLE && w_req) begin
                r_write <= ~ReadEnable;
                r_width <= DataWidth;
                r_addr  <= MemoryAddress;
                r_wdata <= DataOut;
                r_cnt   <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + TIMEOUT_W'(1);
            end
            if (r_state == WAIT_R && BusReadValid)
                r_data <= w_ld_data;
            else if (w_fault_set && (r_state != IDLE || ReadEnable))
                r_data <= '0;
        end
    end

    sol32_lane_align u_align (
        .i_width (r_width),
        .i_addr  (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (BusReadData),
        .o_be    (BusByteEnable),
        .o_wdata (BusWriteData),
        .o_rdata (w_ld_data)
    );

    assign ReadComplete  = ~ReadEnable  | (r_state == DONE);
    assign WriteComplete = ~WriteEnable | (r_state == DONE);
    assign BusValid      = (r_state == REQ);
    assign BusWrite      = r_write;
    assign BusAddress    = {r_addr[31:2], 2'b00};
    assign Fault         = r_fault;
    assign DataIn        = r_data;

endmodule

// File: tb/tb_sol32_lsu.sv
// Directed bench for sol32_lsu: vector table of single accesses plus timeout/reset/alignment sequences.
module tb_sol32_lsu;

    logic        Clock = 1'b0;
    logic        Reset, ReadEnable, WriteEnable;
    logic [1:0]  DataWidth;
    logic [31:0] MemoryAddress, DataOut, DataIn;
    logic        ReadComplete, WriteComplete, Fault, BusValid, BusWrite;
    logic [31:0] BusAddress, BusWriteData;
    logic [3:0]  BusByteEnable;
    logic        BusReady, BusReadValid;
    logic [31:0] BusReadData;

    sol32_lsu dut (
        .Clock(Clock), .Reset(Reset), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
        .DataWidth(DataWidth), .MemoryAddress(MemoryAddress), .DataOut(DataOut), .DataIn(DataIn),
        .ReadComplete(ReadComplete), .WriteComplete(WriteComplete), .Fault(Fault),
        .BusValid(BusValid), .BusWrite(BusWrite), .BusAddress(BusAddress),
        .BusByteEnable(BusByteEnable), .BusWriteData(BusWriteData), .BusReady(BusReady),
        .BusReadValid(BusReadValid), .BusReadData(BusReadData)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        wr;
        logic [1:0]  w;
        logic [31:0] addr, wdata, rdata, e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_din;
    } vec_t;

    vec_t        vecs[8];
    int          n_pass = 0, n_tot = 0;
    logic [31:0] last_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        @(negedge Clock);
        ReadEnable = ~v.wr; WriteEnable = v.wr;
        DataWidth = v.w; MemoryAddress = v.addr; DataOut = v.wdata;
        #1 check($sformatf("v%0d complete low at enable", i), v.wr ? WriteComplete : ReadComplete, 0);
        @(negedge Clock);
        check($sformatf("v%0d BusValid", i), BusValid, 1);
        check($sformatf("v%0d BusWrite", i), BusWrite, v.wr);
        check($sformatf("v%0d BusAddress", i), BusAddress, v.e_addr);
        check($sformatf("v%0d BusByteEnable", i), BusByteEnable, v.e_be);
        if (v.wr) check($sformatf("v%0d BusWriteData", i), BusWriteData, v.e_wd);
        check($sformatf("v%0d complete low in REQ", i), v.wr ? WriteComplete : ReadComplete, 0);
        BusReady = 1;
        @(negedge Clock);
        BusReady = 0;
        if (!v.wr) begin
            check($sformatf("v%0d WAIT_R BusValid", i), BusValid, 0);
            check($sformatf("v%0d WAIT_R complete low", i), ReadComplete, 0);
            BusReadValid = 1; BusReadData = v.rdata;
            @(negedge Clock);
            BusReadValid = 0;
            last_din = v.e_din;
        end
        check($sformatf("v%0d complete high in DONE", i), v.wr ? WriteComplete : ReadComplete, 1);
        check($sformatf("v%0d DataIn", i), DataIn, last_din);
        check($sformatf("v%0d Fault", i), Fault, 0);
        ReadEnable = 0; WriteEnable = 0;
        @(negedge Clock);
        check($sformatf("v%0d idle BusValid", i), BusValid, 0);
        check($sformatf("v%0d DataIn held", i), DataIn, last_din);
    endtask

    initial begin
        int cnt;
        //          wr  w      addr          wdata         rdata         e_addr        e_be     e_wd          e_din
        vecs[0] = '{0, 2'b10, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1] = '{1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0,        32'h0000_0200, 4'b1000, 32'hA500_0000, 32'h0};
        vecs[2] = '{0, 2'b01, 32'h0000_0302, 32'h0,        32'h1234_5678, 32'h0000_0300, 4'b1100, 32'h0,        32'h0000_1234};
        vecs[3] = '{0, 2'b00, 32'h0000_0101, 32'h0,        32'h1234_5678, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_0056};
        vecs[4] = '{1, 2'b01, 32'h0000_0402, 32'hFFFF_BEEF, 32'h0,        32'h0000_0400, 4'b1100, 32'hBEEF_0000, 32'h0};
        vecs[5] = '{1, 2'b10, 32'h0000_0500, 32'h1122_3344, 32'h0,        32'h0000_0500, 4'b1111, 32'h1122_3344, 32'h0};
        vecs[6] = '{0, 2'b00, 32'h0000_0003, 32'h0,        32'h8000_0000, 32'h0000_0000, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[7] = '{0, 2'b11, 32'h0000_0600, 32'h0,        32'hCAFE_F00D, 32'h0000_0600, 4'b1111, 32'h0,        32'hCAFE_F00D};

        Reset = 1; ReadEnable = 0; WriteEnable = 0; DataWidth = 0; MemoryAddress = 0; DataOut = 0;
        BusReady = 0; BusReadValid = 0; BusReadData = 0; last_din = 0;
        repeat (2) @(negedge Clock);
        check("reset BusValid", BusValid, 0);
        check("reset Fault", Fault, 0);
        check("reset DataIn", DataIn, 0);
        check("reset ReadComplete", ReadComplete, 1);
        Reset = 0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while waiting for read data; the late response must be dropped.
        @(negedge Clock);
        ReadEnable = 1; DataWidth = 2'b10; MemoryAddress = 32'h0000_0800;
        @(negedge Clock);
        BusReady = 1;
        @(negedge Clock);
        BusReady = 0;
        check("rst WAIT_R BusValid", BusValid, 0);
        check("rst WAIT_R ReadComplete", ReadComplete, 0);
        Reset = 1;
        @(negedge Clock);
        check("rst BusValid", BusValid, 0);
        check("rst DataIn", DataIn, 0);
        check("rst ReadComplete still low", ReadComplete, 0);
        Reset = 0; ReadEnable = 0; BusReadValid = 1; BusReadData = 32'h7777_7777;
        @(negedge Clock);
        BusReadValid = 0;
        check("rst stale BusReadValid DataIn", DataIn, 0);
        check("rst stale BusValid", BusValid, 0);

        // Word store to a misaligned address.
        @(negedge Clock);
        WriteEnable = 1; DataWidth = 2'b10; MemoryAddress = 32'h0000_0101; DataOut = 32'h0BAD_F00D;
        #1 check("mis WriteComplete low", WriteComplete, 0);
`ifdef SOL32_LSU_ALIGN_CHECK_EN
        check("mis no BusValid", BusValid, 0);
        @(negedge Clock);
        check("mis DONE BusValid", BusValid, 0);
        check("mis Fault", Fault, 1);
        check("mis WriteComplete high", WriteComplete, 1);
        WriteEnable = 0;
        @(negedge Clock);
        check("mis Fault one cycle", Fault, 0);
`else
        @(negedge Clock);
        check("mis BusValid", BusValid, 1);
        check("mis BusAddress", BusAddress, 32'h0000_0100);
        check("mis BusByteEnable", BusByteEnable, 4'b1111);
        BusReady = 1;
        @(negedge Clock);
        BusReady = 0;
        check("mis WriteComplete high", WriteComplete, 1);
        check("mis Fault", Fault, 0);
        WriteEnable = 0;
        @(negedge Clock);
`endif

        // Load a known value so the timeout's DataIn clear is observable.
        run_vec(8, vecs[7]);

        // Slave never accepts: expect abort after 255 cycles of BusValid.
        @(negedge Clock);
        ReadEnable = 1; DataWidth = 2'b10; MemoryAddress = 32'h0000_0700;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge Clock);
            if (!BusValid) break;
            cnt++;
        end
        check("timeout BusValid cycles", cnt, 255);
        check("timeout Fault", Fault, 1);
        check("timeout ReadComplete", ReadComplete, 1);
        check("timeout DataIn", DataIn, 0);
        ReadEnable = 0; BusReadValid = 1; BusReadData = 32'h5555_5555;
        @(negedge Clock);
        BusReadValid = 0;
        check("timeout Fault one cycle", Fault, 0);
        check("timeout late data ignored", DataIn, 0);
        check("timeout idle BusValid", BusValid, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
